// File: rtl/counting_sort_pkg.sv
// Types and helpers shared by the histogram sorters.
// State encoding for the load/emit sequencer and the counter width calculation.
package counting_sort_pkg;

   typedef enum logic {LOAD, EMIT} cs_state_e;

   // A bin can hold every key of a full batch, so it must represent 0..depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/counting_sort_hist.sv
// Per-key occurrence counters: one increment port, one decrement port, one combinational read.
// Updates take effect on the next clock; the read port reflects the current count.
module counting_sort_hist
   import counting_sort_pkg::*;
#(
   parameter int KEY_WIDTH = 5,
   parameter int CNT_W     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc_en_i,
   input  logic [KEY_WIDTH-1:0] inc_addr_i,
   input  logic                 dec_en_i,
   input  logic [KEY_WIDTH-1:0] dec_addr_i,
   input  logic [KEY_WIDTH-1:0] rd_addr_i,
   output logic [CNT_W-1:0]     rd_cnt_o
);

   localparam int NUM_BINS = 2 ** KEY_WIDTH;

   logic [CNT_W-1:0] cnt_q [NUM_BINS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= '0;
      end else begin
         if (inc_en_i) cnt_q[inc_addr_i] <= cnt_q[inc_addr_i] + CNT_W'(1);
         if (dec_en_i) cnt_q[dec_addr_i] <= cnt_q[dec_addr_i] - CNT_W'(1);
      end
   end

   assign rd_cnt_o = cnt_q[rd_addr_i];

   // Loading and emitting are mutually exclusive phases, so the ports never collide.
   inc_dec_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc_en_i && dec_en_i));

endmodule

// File: rtl/counting_sort_stream.sv
// Streaming counting sort: loads up to DEPTH keys into a histogram, then scans bins in order.
// One key per cycle each way plus one cycle per empty bin; read side holds data while stalled.
module counting_sort_stream
   import counting_sort_pkg::*;
#(
   parameter int KEY_WIDTH = 5,
   parameter int DEPTH     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 write_valid_i,
   output logic                 write_ready_o,
   input  logic [KEY_WIDTH-1:0] write_data_i,
   input  logic                 write_last_i,
   input  logic                 desc_i,
   output logic                 read_valid_o,
   input  logic                 read_ready_i,
   output logic [KEY_WIDTH-1:0] read_data_o,
   output logic                 read_last_o,
   output logic                 busy_o
);

   localparam int CNT_W = cnt_width(DEPTH);

   cs_state_e            state_q, state_d;
   logic [CNT_W-1:0]     n_q, n_d;
   logic [KEY_WIDTH-1:0] bin_q, bin_d;
   logic                 desc_q, desc_d;
   logic                 wr_rdy_q, wr_rdy_d;

   logic [CNT_W-1:0]     cur_cnt;
   logic                 wr_fire, rd_vld, rd_last, rd_fire;
   logic [KEY_WIDTH-1:0] bin_step;

   assign wr_fire  = write_valid_i && wr_rdy_q;
   assign rd_vld   = (state_q == EMIT) && (cur_cnt != '0);
   assign rd_last  = rd_vld && (n_q == CNT_W'(1));
   assign rd_fire  = rd_vld && read_ready_i;
   assign bin_step = desc_q ? bin_q - KEY_WIDTH'(1) : bin_q + KEY_WIDTH'(1);

   counting_sort_hist #(
      .KEY_WIDTH (KEY_WIDTH),
      .CNT_W     (CNT_W)
   ) u_hist (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_en_i   (wr_fire),
      .inc_addr_i (write_data_i),
      .dec_en_i   (rd_fire),
      .dec_addr_i (bin_q),
      .rd_addr_i  (bin_q),
      .rd_cnt_o   (cur_cnt)
   );

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      bin_d    = bin_q;
      desc_d   = desc_q;
      wr_rdy_d = wr_rdy_q;
      case (state_q)
         LOAD: begin
            if (wr_fire) begin
               n_d = n_q + CNT_W'(1);
               if (n_q == '0) desc_d = desc_i;
               if (write_last_i || (n_q + CNT_W'(1) == CNT_W'(DEPTH))) begin
                  state_d  = EMIT;
                  wr_rdy_d = 1'b0;
                  bin_d    = desc_d ? '1 : '0;
               end
            end
         end
         EMIT: begin
            if (cur_cnt == '0) begin
               bin_d = bin_step;
            end else if (read_ready_i) begin
               if (rd_last) begin
                  state_d  = LOAD;
                  wr_rdy_d = 1'b1;
                  n_d      = '0;
               end else begin
                  n_d = n_q - CNT_W'(1);
                  // Stay on a bin until its last duplicate has gone out.
                  if (cur_cnt == CNT_W'(1)) bin_d = bin_step;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= LOAD;
         n_q      <= '0;
         bin_q    <= '0;
         desc_q   <= 1'b0;
         wr_rdy_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         bin_q    <= bin_d;
         desc_q   <= desc_d;
         wr_rdy_q <= wr_rdy_d;
      end
   end

   assign write_ready_o = wr_rdy_q;
   assign read_valid_o  = rd_vld;
   assign read_data_o   = bin_q;
   assign read_last_o   = rd_last;
   assign busy_o        = (state_q == EMIT) || (n_q != '0);

endmodule

// File: tb/tb_counting_sort_stream.sv
// Directed bench for counting_sort_stream: ordering, duplicates, stalls, scan time, reset, chaining.
module tb_counting_sort_stream;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       write_valid_i = 1'b0;
   logic       write_ready_o;
   logic [4:0] write_data_i = '0;
   logic       write_last_i = 1'b0;
   logic       desc_i = 1'b0;
   logic       read_valid_o;
   logic       read_ready_i = 1'b0;
   logic [4:0] read_data_o;
   logic       read_last_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;
   int wkeys[$];
   int exp_q[$];
   int idle;

   counting_sort_stream #(.KEY_WIDTH(5), .DEPTH(8)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .write_valid_i (write_valid_i),
      .write_ready_o (write_ready_o),
      .write_data_i  (write_data_i),
      .write_last_i  (write_last_i),
      .desc_i        (desc_i),
      .read_valid_o  (read_valid_o),
      .read_ready_i  (read_ready_i),
      .read_data_o   (read_data_o),
      .read_last_o   (read_last_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Offer every key of wkeys on consecutive cycles; desc_i flips after the first beat.
   task automatic send(input string name, input bit last_on_final, input bit desc);
      for (int i = 0; i < wkeys.size(); i++) begin
         write_valid_i = 1'b1;
         write_data_i  = 5'(wkeys[i]);
         write_last_i  = last_on_final && (i == wkeys.size() - 1);
         desc_i        = (i == 0) ? desc : ~desc;
         checks++;
         if (write_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s write_ready beat %0d: got %b, required 1", name, i, write_ready_o);
         end
         cycle();
      end
      write_valid_i = 1'b0;
      write_last_i  = 1'b0;
      checks++;
      if (write_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL %s emit entry: got ready=%b busy=%b, required ready=0 busy=1",
                  name, write_ready_o, busy_o);
      end
   endtask

   // Drain n_take keys, checking each against exp_q and stability during stalls.
   task automatic collect(input string name, input int n_take, input bit bp, output int idle_before);
      int  idx = 0;
      int  budget = 0;
      bit  prev_stall = 0;
      logic [4:0] prev_d = '0;
      logic prev_l = 0;
      logic v, l, rdy;
      logic [4:0] d;
      idle_before = 0;
      while (idx < n_take && budget < 400) begin
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         read_ready_i = rdy;
         v = read_valid_o;
         d = read_data_o;
         l = read_last_o;
         if (prev_stall) begin
            checks++;
            if (v !== 1'b1 || d !== prev_d || l !== prev_l) begin
               errors++;
               $display("FAIL %s stall hold: got v=%b d=%0d l=%b, required v=1 d=%0d l=%b",
                        name, v, d, l, prev_d, prev_l);
            end
         end
         if (v === 1'b1 && rdy) begin
            checks++;
            if (d !== 5'(exp_q[idx])) begin
               errors++;
               $display("FAIL %s key %0d: got %0d, required %0d", name, idx, d, exp_q[idx]);
            end
            checks++;
            if (l !== (idx == exp_q.size() - 1)) begin
               errors++;
               $display("FAIL %s last %0d: got %b, required %b", name, idx, l,
                        idx == exp_q.size() - 1);
            end
            idx++;
         end else if (idx == 0 && v !== 1'b1) begin
            idle_before++;
         end
         prev_stall = (v === 1'b1) && !rdy;
         prev_d = d;
         prev_l = l;
         cycle();
         budget++;
      end
      read_ready_i = 1'b0;
      if (idx < n_take) begin
         checks++;
         errors++;
         $display("FAIL %s drain timeout: got %0d keys, required %0d", name, idx, n_take);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (write_ready_o !== 1'b1 || read_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: got ready=%b valid=%b busy=%b, required 1 0 0",
                  name, write_ready_o, read_valid_o, busy_o);
      end
   endtask

   task automatic test_reset();
      cycle();
      checks++;
      if (write_ready_o !== 1'b1 || read_valid_o !== 1'b0 || read_last_o !== 1'b0 ||
          read_data_o !== 5'd0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got ready=%b valid=%b last=%b data=%0d busy=%b, required 1 0 0 0 0",
                  write_ready_o, read_valid_o, read_last_o, read_data_o, busy_o);
      end
      rst_ni = 1'b1;
      cycle();
      check_idle("post_reset");
   endtask

   task automatic test_asc_full();
      wkeys = '{7, 3, 31, 3, 0, 12, 3, 20};
      exp_q = '{0, 3, 3, 3, 7, 12, 20, 31};
      send("asc_full", 1'b0, 1'b0);
      collect("asc_full", 8, 1'b0, idle);
      check_idle("asc_full");
   endtask

   task automatic test_desc_short();
      wkeys = '{5, 9, 1};
      exp_q = '{9, 5, 1};
      send("desc_short", 1'b1, 1'b1);
      collect("desc_short", 3, 1'b0, idle);
      check_idle("desc_short");
      checks++;
      begin
         int nz = 0;
         for (int b = 0; b < 32; b++) if (dut.u_hist.cnt_q[b] != 0) nz++;
         if (nz != 0) begin
            errors++;
            $display("FAIL desc_short bins_clear: got %0d nonzero bins, required 0", nz);
         end
      end
   endtask

   task automatic test_backpressure();
      wkeys = '{7, 3, 31, 3, 0, 12, 3, 20};
      exp_q = '{0, 3, 3, 3, 7, 12, 20, 31};
      send("backpressure", 1'b0, 1'b0);
      collect("backpressure", 8, 1'b1, idle);
      check_idle("backpressure");
   endtask

   task automatic test_single();
      wkeys = '{31};
      exp_q = '{31};
      send("single", 1'b1, 1'b0);
      collect("single", 1, 1'b0, idle);
      checks++;
      if (idle != 31) begin
         errors++;
         $display("FAIL single scan_cycles: got %0d, required 31", idle);
      end
      check_idle("single");
   endtask

   task automatic test_reset_mid_emit();
      wkeys = '{7, 3, 31, 3, 0, 12, 3, 20};
      exp_q = '{0, 3, 3, 3, 7, 12, 20, 31};
      send("mid_reset", 1'b0, 1'b0);
      collect("mid_reset", 2, 1'b0, idle);
      rst_ni = 1'b0;
      #1;
      check_idle("mid_reset_async");
      cycle();
      rst_ni = 1'b1;
      cycle();
      check_idle("mid_reset_after");
      wkeys = '{2, 1};
      exp_q = '{1, 2};
      send("mid_reset_next", 1'b1, 1'b0);
      collect("mid_reset_next", 2, 1'b0, idle);
      check_idle("mid_reset_next");
   endtask

   task automatic test_back_to_back();
      wkeys = '{4, 2};
      exp_q = '{2, 4};
      send("b2b_a", 1'b1, 1'b0);
      collect("b2b_a", 2, 1'b0, idle);
      wkeys = '{6, 8, 6};
      exp_q = '{8, 6, 6};
      send("b2b_b", 1'b1, 1'b1);
      collect("b2b_b", 3, 1'b0, idle);
      wkeys = '{17, 16};
      exp_q = '{16, 17};
      send("b2b_c", 1'b1, 1'b0);
      collect("b2b_c", 2, 1'b0, idle);
      check_idle("b2b_end");
   endtask

   initial begin
      test_reset();
      test_asc_full();
      test_desc_short();
      test_backpressure();
      test_single();
      test_reset_mid_emit();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
